// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: issues sequential fetches, buffers responses in a
// circular queue for decode, and flushes/refetches on redirect or reset.
module fetch_queue_unit #(
    parameter int               XLEN        = 32,
    parameter int               QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0]  RESET_PC    = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           resetN,
    output logic [XLEN-1:0]                imemAddress,
    output logic                           imemReadEnable,
    input  logic [31:0]                    imemInstruction,
    input  logic                           redirectValid,
    input  logic [XLEN-1:0]                redirectTarget,
    input  logic                           decodeReady,
    output logic                           decodeValid,
    output logic [31:0]                    decodeInstruction,
    output logic [XLEN-1:0]                decodePc,
    output logic [$clog2(QUEUE_DEPTH):0]   queueCount
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_flight_pc;
    logic            r_in_flight;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_q_instr [QUEUE_DEPTH];
    logic [XLEN-1:0] r_q_pc    [QUEUE_DEPTH];

    logic            w_not_empty;
    logic            w_pop;
    logic            w_req;
    logic            w_push;
    logic [CW-1:0]   w_occupancy;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_not_empty   = (r_count != {CW{1'b0}});
    assign w_pop         = w_not_empty & decodeReady;
    // Occupancy counts the in-flight slot so a response always has room to land.
    assign w_occupancy   = r_count + CW'(r_in_flight) - CW'(w_pop);
    assign w_req         = resetN & ~redirectValid & (w_occupancy < CW'(QUEUE_DEPTH));
    assign w_push        = resetN & ~redirectValid & r_in_flight;
    assign w_redirect_pc = redirectTarget & ~XLEN'(2'b11);

    assign imemAddress       = r_fetch_pc;
    assign imemReadEnable    = w_req;
    assign decodeValid       = w_not_empty;
    assign decodeInstruction = w_not_empty ? r_q_instr[r_head] : 32'd0;
    assign decodePc          = w_not_empty ? r_q_pc[r_head] : {XLEN{1'b0}};
    assign queueCount        = r_count;

    // Control state; a redirect drops the pending response simply by not pushing it.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_fetch_pc  <= RESET_PC;
            r_flight_pc <= {XLEN{1'b0}};
            r_in_flight <= 1'b0;
            r_head      <= {PW{1'b0}};
            r_tail      <= {PW{1'b0}};
            r_count     <= {CW{1'b0}};
        end else if (redirectValid) begin
            r_fetch_pc  <= w_redirect_pc;
            r_in_flight <= 1'b0;
            r_head      <= {PW{1'b0}};
            r_tail      <= {PW{1'b0}};
            r_count     <= {CW{1'b0}};
        end else begin
            r_in_flight <= w_req;
            if (w_req) begin
                r_flight_pc <= r_fetch_pc;
                r_fetch_pc  <= r_fetch_pc + XLEN'(3'd4);
            end
            if (w_push) begin
                r_tail <= r_tail + PW'(1'b1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1'b1);
            end
            r_count <= w_occupancy;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_tail] <= imemInstruction;
            r_q_pc[r_tail]    <= r_flight_pc;
        end
    end

endmodule
